channel_packer: RTL
===================

CHANNEL_PACKER -- requirements
Module: channel_packer

Interface
REQ-001 Parameter DATA_WIDTH, default 16, bit width of one channel word.
REQ-002 Parameter OUT_CHANNEL, default 16, number of channel words in one output vector.
REQ-003 Parameter IN_PAR, default 1, channel words per input beat; OUT_CHANNEL % IN_PAR == 0 is required; BEATS = OUT_CHANNEL/IN_PAR.
REQ-004 clk  input  1  sole clock, all state on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 i_data  input  DATA_WIDTH*IN_PAR  input beat, word j in bits [(j+1)*DATA_WIDTH-1 : j*DATA_WIDTH].
REQ-007 i_valid  input  1  input beat valid.
REQ-008 o_ready  output  1  block can accept an input beat this cycle.
REQ-009 i_flush  input  1  close the current partial vector with zero padding.
REQ-010 o_data  output  DATA_WIDTH*OUT_CHANNEL  packed vector, channel c in bits [(c+1)*DATA_WIDTH-1 : c*DATA_WIDTH].
REQ-011 o_valid  output  1  o_data holds a complete vector.
REQ-012 i_ready  input  1  downstream accepts o_data this cycle.
REQ-013 o_beat_cnt  output  clog2(BEATS+1)  beats accepted into the current assembly vector.

Function
REQ-014 An input beat is accepted exactly when i_valid && o_ready at a rising edge; an output vector is consumed exactly when o_valid && i_ready.
REQ-015 Beat k (0-based) of a vector is written to channels k*IN_PAR .. k*IN_PAR+IN_PAR-1; the first beat lands in channel 0 (LSB).
REQ-016 Storage: one assembly register (OUT_CHANNEL words + full flag) and one output register (OUT_CHANNEL words + o_valid).
REQ-017 Completion: a vector completes on acceptance of beat BEATS-1, or on a flush event (REQ-021/022).
REQ-018 On completion, if the output register is empty or is consumed in the same cycle, the vector moves into the output register at that edge; o_valid is asserted the cycle after the completing beat is accepted (latency 1).
REQ-019 Otherwise the completed vector stays in the assembly register with the full flag set; it moves to the output register at the edge on which the held output is consumed.
REQ-020 o_ready = NOT assembly-full; combinational from registered state only, with no path from i_ready or i_valid.
REQ-021 i_flush with an accepted beat: that beat is written, all higher channels are set to zero, and the vector completes.
REQ-022 i_flush without an accepted beat: if o_beat_cnt > 0 and the assembly register is not full, the vector completes with unfilled channels zero; if o_beat_cnt == 0, it has no effect.
REQ-023 i_flush while the assembly register is full is ignored.
REQ-024 o_beat_cnt wraps to 0 on completion; it never reaches BEATS as a stable value.
REQ-025 Sustained throughput is one beat per cycle with i_ready held high; no bubble at vector boundaries.
REQ-026 o_data and o_valid are stable while o_valid && !i_ready.
REQ-027 Zero padding from REQ-021/022 is also applied to any channels left stale from a previous vector.

Reset
REQ-028 With rst high at a rising edge: o_valid=0, assembly full=0, o_beat_cnt=0, o_ready=1 after the edge.
REQ-029 Data registers need no reset, but o_data reads 0 after reset and before the first vector.
REQ-030 Reset mid-vector or mid-stall discards all partial and held vectors.
REQ-031 rst takes priority over i_valid, i_flush and i_ready in the same cycle.

Verification
REQ-032 Streaming: OUT_CHANNEL=4, IN_PAR=1, i_ready=1, beats 1,2,3,4,5,6,7,8 back-to-back -> o_valid pulses one cycle after beat 4 with channels{0..3}={1,2,3,4}, and one cycle after beat 8 with {5,6,7,8}; o_ready stays 1 throughout.
REQ-033 Backpressure: same setup, i_ready=0, 8 beats offered -> first vector held in the output register, second vector assembled and held, o_ready=0 after beat 8; raise i_ready -> {1,2,3,4} then {5,6,7,8} on consecutive cycles, o_ready returns to 1.
REQ-034 Parallel input: OUT_CHANNEL=8, IN_PAR=2, beats {1,2},{3,4},{5,6},{7,8} -> one vector with channels 0..7 = 1..8 after 4 beats.
REQ-035 Flush: OUT_CHANNEL=4, beats 9,10 then i_flush alone -> vector {9,10,0,0}, o_beat_cnt back to 0; i_flush with o_beat_cnt=0 -> no o_valid.
REQ-036 Reset: assert rst after 2 beats while o_valid=1 and i_ready=0 -> next cycle o_valid=0, o_beat_cnt=0, o_ready=1; the following 4 beats produce a clean vector.

Source files
------------

// File: rtl/channel_packer.sv
// Packs IN_PAR-word input beats into OUT_CHANNEL-word vectors, with one assembly
// stage and one output stage, optional early close (flush) with zero padding.
module channel_packer #(
    parameter  int DATA_WIDTH  = 16,
    parameter  int OUT_CHANNEL = 16,
    parameter  int IN_PAR      = 1,
    localparam int BEATS       = OUT_CHANNEL / IN_PAR,
    localparam int CNT_W       = $clog2(BEATS + 1)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [DATA_WIDTH*IN_PAR-1:0]      i_data,
    input  logic                              i_valid,
    output logic                              o_ready,
    input  logic                              i_flush,
    output logic [DATA_WIDTH*OUT_CHANNEL-1:0] o_data,
    output logic                              o_valid,
    input  logic                              i_ready,
    output logic [CNT_W-1:0]                  o_beat_cnt
);

    localparam int BEAT_W = DATA_WIDTH * IN_PAR;
    localparam int VEC_W  = DATA_WIDTH * OUT_CHANNEL;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    if (OUT_CHANNEL % IN_PAR != 0) begin : g_bad_par
        $error("OUT_CHANNEL must be a multiple of IN_PAR");
    end

    logic [VEC_W-1:0] asm_data;
    logic [VEC_W-1:0] asm_next;
    logic [VEC_W-1:0] out_data;
    logic             asm_full;
    logic             out_valid;
    logic [CNT_W-1:0] beat_cnt;
    logic             accept;
    logic             out_free;
    logic             complete;

    assign o_ready    = !asm_full;
    assign o_data     = out_data;
    assign o_valid    = out_valid;
    assign o_beat_cnt = beat_cnt;

    assign accept   = i_valid && !asm_full;
    assign out_free = !out_valid || i_ready;
    assign complete = !asm_full &&
                      ((accept && (beat_cnt == LAST_BEAT || i_flush)) ||
                       (!accept && i_flush && beat_cnt != '0));

    // The first beat of a vector clears every higher channel, so a flushed vector
    // is already zero-padded and never carries stale words from the previous one.
    always_comb begin
        asm_next = (beat_cnt == '0) ? '0 : asm_data;
        if (accept) begin
            for (int b = 0; b < BEATS; b++) begin
                if (beat_cnt == CNT_W'(b)) begin
                    asm_next[b*BEAT_W +: BEAT_W] = i_data;
                end
            end
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples the
    // pre-edge values; the blocking style above is reserved for the comb block.
    always_ff @(posedge clk) begin
        if (rst) begin
            asm_full  <= 1'b0;
            beat_cnt  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (asm_full) begin
            if (out_free) begin
                out_data  <= asm_data;
                out_valid <= 1'b1;
                asm_full  <= 1'b0;
            end
        end else if (complete) begin
            beat_cnt <= '0;
            if (out_free) begin
                out_data  <= asm_next;
                out_valid <= 1'b1;
            end else begin
                asm_full <= 1'b1;
            end
        end else begin
            if (accept) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
            if (out_valid && i_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // NOTE: the assembly words carry no reset; beat_cnt returning to zero makes the
    // next first beat overwrite them before they can ever be observed.
    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            asm_data <= asm_next;
        end
    end

endmodule
